// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Holds the PC, drives the ROM word address and registers the fetched word
// into an IF/ID slot with a valid/ready handshake toward decode.
// Out-of-range fetches produce a single NOP fault entry and then halt until redirected.
// Optional build macro FETCH_MISALIGN_TRAP_EN: keep all 32 redirect bits and
// fault on a misaligned PC instead of silently aligning the redirect target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned I_MEMSIZE = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] MEM_WORDS        = 32'(I_MEMSIZE);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, pc_inc;
  logic        valid_next, fault_next;
  logic [31:0] instr_next, slot_pc_next, plus4_next;
  logic [31:0] redirect_target;
  logic        load, out_of_range, misaligned, fetch_err;

  assign imem_addr = pc[31:2];
  assign pc_inc    = pc + 32'd4;

  // Next-state and next-slot decision: redirect first, then fetch/fault handling per state.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    valid_next   = if_valid;
    fault_next   = fetch_fault;
    instr_next   = if_instr;
    slot_pc_next = if_pc;
    plus4_next   = if_pc_plus4;

    load         = !if_valid || id_ready;
    out_of_range = {2'b00, pc[31:2]} >= MEM_WORDS;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned      = pc[1:0] != 2'b00;
    redirect_target = redirect_pc;
`else
    misaligned      = 1'b0;
    redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif
    fetch_err = out_of_range || misaligned;

    if (redirect_valid) begin
      pc_next    = redirect_target;
      valid_next = 1'b0;
      fault_next = 1'b0;
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (load) begin
            valid_next   = 1'b1;
            slot_pc_next = pc;
            plus4_next   = pc_inc;
            if (fetch_err) begin
              instr_next = NOP_INSTR;
              fault_next = 1'b1;
              state_next = FAULT;
            end else begin
              instr_next = imem_rdata;
              fault_next = 1'b0;
              pc_next    = pc_inc;
            end
          end
        end
        FAULT: begin
          if (id_ready) begin
            valid_next = 1'b0;
            state_next = HALT;
          end
        end
        HALT: begin
          valid_next = 1'b0;
        end
        default: begin
          valid_next = 1'b0;
          state_next = RUN;
        end
      endcase
    end
  end

  // State, PC and IF/ID slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC_ALIGNED;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc       <= RESET_PC_ALIGNED;
      if_pc_plus4 <= RESET_PC_ALIGNED + 32'd4;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_valid    <= valid_next;
      if_instr    <= instr_next;
      if_pc       <= slot_pc_next;
      if_pc_plus4 <= plus4_next;
      fetch_fault <= fault_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// The expected instruction stream after every reset/redirect is computed from
// the fetch rules (sequential words until the ROM ends, then one fault entry)
// and queued; a monitor pops and compares on every decode handshake.
module tb_fetch_unit;

  localparam int          MEM      = 100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic [29:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_fault;

  logic [31:0] rom [0:MEM-1];
  entry_t      exp_q [$];
  int          checks = 0;
  int          errors = 0;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .I_MEMSIZE (MEM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  assign imem_rdata = (int'(imem_addr) < MEM) ? rom[int'(imem_addr)] : 32'hDEAD_BEEF;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Expected stream starting at a target PC: sequential words until the PC
  // leaves the ROM (or is misaligned when trapping), closed by one fault entry.
  task automatic loadStream(input logic [31:0] target);
    logic [31:0] p;
    entry_t      e;
    exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
    p = target;
`else
    p = target & 32'hFFFF_FFFC;
`endif
    while (p[1:0] == 2'b00 && (p >> 2) < 32'(MEM)) begin
      e.instr = rom[int'(p >> 2)];
      e.pc    = p;
      e.fault = 1'b0;
      exp_q.push_back(e);
      p = p + 32'd4;
    end
    e.instr = NOP;
    e.pc    = p;
    e.fault = 1'b1;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs and return just after the next rising edge.
  task automatic applyStimulus(input logic rst_val, input logic rv, input logic [31:0] rp, input logic rdy);
    rst_n          = rst_val;
    redirect_valid = rv;
    redirect_pc    = rp;
    id_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doRedirect(input logic [31:0] target);
    applyStimulus(1'b1, 1'b1, target, id_ready);
    redirect_valid = 1'b0;
    loadStream(target);
    checkOutput("redirect_bubble_valid", 32'(if_valid), 32'd0);
    checkOutput("redirect_imem_addr", 32'(imem_addr), {2'b00, target[31:2]});
  endtask

  task automatic checkResetValues();
    checkOutput("reset_if_valid", 32'(if_valid), 32'd0);
    checkOutput("reset_if_instr", if_instr, NOP);
    checkOutput("reset_if_pc", if_pc, 32'd0);
    checkOutput("reset_if_pc_plus4", if_pc_plus4, 32'd4);
    checkOutput("reset_fetch_fault", 32'(fetch_fault), 32'd0);
    checkOutput("reset_imem_addr", 32'(imem_addr), 32'd0);
  endtask

  // Monitor: every handshake must match the head of the expected stream.
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_slot_pc", if_pc, 32'hFFFF_FFFF);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        checkOutput("if_instr", if_instr, e.instr);
        checkOutput("if_pc", if_pc, e.pc);
        checkOutput("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
        checkOutput("fetch_fault", 32'(fetch_fault), 32'(e.fault));
      end
    end
  end

  // Runaway guard so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    for (int i = 0; i < MEM; i++) rom[i] = $urandom;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b1;

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkResetValues();

    // Release reset: A appears on the first edge, then B, then a 3-cycle stall.
    rst_n = 1'b1;
    loadStream(32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("first_valid", 32'(if_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput("stall_if_pc", if_pc, 32'd4);
      checkOutput("stall_if_instr", if_instr, rom[1]);
      checkOutput("stall_imem_addr", 32'(imem_addr), 32'd2);
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("after_stall_if_pc", if_pc, 32'd8);

    // Redirect while C sits in the slot.
    doRedirect(32'h40);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Run off the end of the ROM, drain the fault entry, then stay halted.
    doRedirect(32'(4 * (MEM - 5)));
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("fault_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("halt_if_valid", 32'(if_valid), 32'd0);
    end
    doRedirect(32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Misaligned target and wrap-around at the top of the address space.
    doRedirect(32'h0000_0006);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    doRedirect(32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    doRedirect(32'd8);

    // Randomized ready pattern with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0)
        doRedirect(32'($urandom_range(0, 4 * MEM + 12)));
      else
        applyStimulus(1'b1, 1'b0, 32'd0, id_ready);
    end

    // Reset together with a redirect mid-run: reset wins.
    doRedirect(32'h20);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
    checkResetValues();
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    loadStream(32'd0);
    for (int i = 0; i < 30; i++) begin
      id_ready = ($urandom_range(0, 2) != 0);
      applyStimulus(1'b1, 1'b0, 32'd0, id_ready);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
